pixel_write_queue: RTL and testbench

Buffers pixel writes from the drawing FSM/datapath (oX, oY, oColour, plot) and presents them to the framebuffer or VGA adapter write port as linear addresses. The drawer cannot stall, so this block clips off-screen coordinates and absorbs bursts in a small FIFO. It drains under a ready/valid handshake from the memory side. Overflow and clip events are counted for debug.

---
 rtl/pixel_write_queue.sv | 110 +++++++++++
 tb/tb_pixel_write_queue.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/pixel_write_queue.sv
// ============================================================================
// Module      : pixel_write_queue
// Description : Clips drawer pixel writes, buffers them in a FWFT FIFO as
//               linear addresses, and counts clip/overflow events.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module pixel_write_queue #(
    parameter int X_SCREEN_PIXELS = 160,
    parameter int Y_SCREEN_PIXELS = 120,
    parameter int DEPTH           = 16,
    parameter int ADDR_W          = 15
) (
    input  logic              iClock,
    input  logic              iResetn,
    input  logic [7:0]        iX,
    input  logic [7:0]        iY,
    input  logic [2:0]        iColour,
    input  logic              iPlot,
    input  logic              iReady,
    output logic [ADDR_W-1:0] oAddr,
    output logic [2:0]        oColour,
    output logic              oWrEn,
    output logic              oFull,
    output logic              oEmpty,
    output logic [7:0]        oDropCount,
    output logic [7:0]        oClipCount
);

    localparam int                PTR_W   = $clog2(DEPTH);
    localparam int                CNT_W   = PTR_W + 1;
    localparam logic [CNT_W-1:0]  C_DEPTH = CNT_W'(DEPTH);
    localparam logic [ADDR_W-1:0] C_XS    = ADDR_W'(X_SCREEN_PIXELS);

    logic [ADDR_W-1:0] r_mem_addr [DEPTH];
    logic [2:0]        r_mem_col  [DEPTH];
    logic [PTR_W-1:0]  r_wr_ptr;
    logic [PTR_W-1:0]  r_rd_ptr;
    logic [CNT_W-1:0]  r_count;
    logic [7:0]        r_drop_cnt;
    logic [7:0]        r_clip_cnt;

    logic              w_in_range;
    logic [ADDR_W-1:0] w_addr;
    logic              w_nonempty;
    logic              w_pop;
    logic              w_room;
    logic              w_push;
    logic              w_drop;
    logic              w_clip;

    // Operands widened to ADDR_W before the multiply so the address never truncates.
    assign w_addr     = ADDR_W'(iY) * C_XS + ADDR_W'(iX);
    assign w_in_range = (32'(iX) < X_SCREEN_PIXELS) && (32'(iY) < Y_SCREEN_PIXELS);

    assign w_nonempty = (r_count != '0);
    assign w_pop      = w_nonempty && iReady;
    assign w_room     = (r_count < C_DEPTH) || w_pop;
    assign w_push     = iPlot && w_in_range && w_room;
    assign w_drop     = iPlot && w_in_range && !w_room;
    assign w_clip     = iPlot && !w_in_range;

    always_ff @(posedge iClock) begin
        if (w_push && iResetn) begin
            r_mem_addr[r_wr_ptr] <= w_addr;
            r_mem_col[r_wr_ptr]  <= iColour;
        end
    end

    always_ff @(posedge iClock) begin
        if (!iResetn) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
            r_drop_cnt <= '0;
            r_clip_cnt <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
            if (w_drop && (r_drop_cnt != 8'hFF)) begin
                r_drop_cnt <= r_drop_cnt + 1'b1;
            end
            if (w_clip && (r_clip_cnt != 8'hFF)) begin
                r_clip_cnt <= r_clip_cnt + 1'b1;
            end
        end
    end

    // Head entry is masked to zero while empty so stale storage never leaks out.
    assign oAddr      = w_nonempty ? r_mem_addr[r_rd_ptr] : '0;
    assign oColour    = w_nonempty ? r_mem_col[r_rd_ptr]  : '0;
    assign oWrEn      = w_nonempty;
    assign oFull      = (r_count == C_DEPTH);
    assign oEmpty     = (r_count == '0);
    assign oDropCount = r_drop_cnt;
    assign oClipCount = r_clip_cnt;

endmodule

`default_nettype wire

// File: tb/tb_pixel_write_queue.sv
// ============================================================================
// Module      : tb_pixel_write_queue
// Description : Directed vector table plus hand sequences for pixel_write_queue.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_pixel_write_queue;

    logic        iClock;
    logic        iResetn;
    logic [7:0]  iX;
    logic [7:0]  iY;
    logic [2:0]  iColour;
    logic        iPlot;
    logic        iReady;
    logic [14:0] oAddr;
    logic [2:0]  oColour;
    logic        oWrEn;
    logic        oFull;
    logic        oEmpty;
    logic [7:0]  oDropCount;
    logic [7:0]  oClipCount;

    int checks;
    int errors;

    pixel_write_queue #(
        .X_SCREEN_PIXELS(160),
        .Y_SCREEN_PIXELS(120),
        .DEPTH(16),
        .ADDR_W(15)
    ) dut (
        .iClock(iClock),
        .iResetn(iResetn),
        .iX(iX),
        .iY(iY),
        .iColour(iColour),
        .iPlot(iPlot),
        .iReady(iReady),
        .oAddr(oAddr),
        .oColour(oColour),
        .oWrEn(oWrEn),
        .oFull(oFull),
        .oEmpty(oEmpty),
        .oDropCount(oDropCount),
        .oClipCount(oClipCount)
    );

    initial iClock = 1'b0;
    always #5 iClock = ~iClock;

    typedef struct {
        logic        plot;
        logic [7:0]  x;
        logic [7:0]  y;
        logic [2:0]  col;
        logic        rdy;
        logic        wren;
        logic [14:0] addr;
        logic [2:0]  ocol;
        logic        full;
        logic        empty;
        logic [7:0]  drop;
        logic [7:0]  clip;
    } vec_t;

    typedef struct {
        logic [14:0] addr;
        logic [2:0]  col;
    } ent_t;

    vec_t vecs[10];
    ent_t model_q[$];

    function automatic vec_t mk(input logic plot, input int x, input int y, input int col,
                                input logic rdy, input logic wren, input int addr, input int ocol,
                                input logic full, input logic empty, input int drop, input int clip);
        vec_t v;
        v.plot = plot; v.x = 8'(x); v.y = 8'(y); v.col = 3'(col); v.rdy = rdy;
        v.wren = wren; v.addr = 15'(addr); v.ocol = 3'(ocol);
        v.full = full; v.empty = empty; v.drop = 8'(drop); v.clip = 8'(clip);
        return v;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic drive(input logic plot, input int x, input int y, input int col, input logic rdy);
        iPlot = plot; iX = 8'(x); iY = 8'(y); iColour = 3'(col); iReady = rdy;
    endtask

    task automatic step();
        @(posedge iClock);
        #1;
    endtask

    function automatic logic [63:0] pack_out();
        return 64'({oWrEn, oAddr, oColour, oFull, oEmpty, oDropCount, oClipCount});
    endfunction

    function automatic logic [63:0] pack_vec(input vec_t v);
        return 64'({v.wren, v.addr, v.ocol, v.full, v.empty, v.drop, v.clip});
    endfunction

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        checks = 0;
        errors = 0;

        //              plot x    y    c rdy  wren addr   oc full empty drop clip
        vecs[0] = mk(1, 5,   3,   4, 1,   1, 485,   4, 0, 0, 0, 0);
        vecs[1] = mk(0, 0,   0,   0, 1,   0, 0,     0, 0, 1, 0, 0);
        vecs[2] = mk(1, 159, 119, 7, 0,   1, 19199, 7, 0, 0, 0, 0);
        vecs[3] = mk(1, 0,   0,   2, 1,   1, 0,     2, 0, 0, 0, 0);
        vecs[4] = mk(0, 0,   0,   0, 1,   0, 0,     0, 0, 1, 0, 0);
        vecs[5] = mk(1, 160, 0,   1, 1,   0, 0,     0, 0, 1, 0, 1);
        vecs[6] = mk(1, 0,   120, 1, 1,   0, 0,     0, 0, 1, 0, 2);
        vecs[7] = mk(1, 255, 255, 1, 1,   0, 0,     0, 0, 1, 0, 3);
        vecs[8] = mk(0, 0,   0,   0, 1,   0, 0,     0, 0, 1, 0, 3);
        vecs[9] = mk(1, 159, 0,   5, 0,   1, 159,   5, 0, 0, 0, 3);

        // Reset held two cycles with plot and ready active
        iResetn = 1'b0;
        drive(1, 5, 3, 4, 1);
        step();
        step();
        chk("reset_state", pack_out(), 64'({1'b0, 15'd0, 3'd0, 1'b0, 1'b1, 8'd0, 8'd0}));
        iResetn = 1'b1;
        drive(0, 0, 0, 0, 0);
        step();

        for (int i = 0; i < 10; i++) begin
            drive(vecs[i].plot, int'(vecs[i].x), int'(vecs[i].y), int'(vecs[i].col), vecs[i].rdy);
            step();
            chk($sformatf("vec%0d", i), pack_out(), pack_vec(vecs[i]));
        end

        // Drain the single leftover entry from vecs[9]
        drive(0, 0, 0, 0, 1);
        step();
        chk("post_vec_empty", 64'(oEmpty), 64'(1));

        // Fill with ready low: 17 pixels, the 17th overflows
        for (int i = 0; i < 17; i++) begin
            drive(1, i, 1, i % 8, 0);
            if (i < 16) model_q.push_back('{addr: 15'(160 + i), col: 3'(i % 8)});
            step();
            if (i == 14) chk("not_full_at_15", 64'(oFull), 64'(0));
            if (i == 15) chk("full_at_16", 64'({oFull, oDropCount}), 64'({1'b1, 8'd0}));
            if (i == 16) chk("drop_at_17", 64'({oFull, oDropCount}), 64'({1'b1, 8'd1}));
        end

        // Full with simultaneous push and pop for 10 cycles
        for (int i = 0; i < 10; i++) begin
            chk($sformatf("fullpp_head%0d", i), 64'({oAddr, oColour}),
                64'({model_q[0].addr, model_q[0].col}));
            void'(model_q.pop_front());
            model_q.push_back('{addr: 15'(2 * 160 + 100 + i), col: 3'((i + 3) % 8)});
            drive(1, 100 + i, 2, (i + 3) % 8, 1);
            step();
            chk($sformatf("fullpp_flags%0d", i), 64'({oFull, oDropCount}), 64'({1'b1, 8'd1}));
        end

        // Drain all 16 in order
        for (int i = 0; i < 16; i++) begin
            drive(0, 0, 0, 0, 1);
            chk($sformatf("drain%0d", i), 64'({oWrEn, oAddr, oColour}),
                64'({1'b1, model_q[0].addr, model_q[0].col}));
            void'(model_q.pop_front());
            step();
        end
        chk("drained_empty", 64'({oWrEn, oEmpty, oFull}), 64'({1'b0, 1'b1, 1'b0}));

        // Clip counter saturation
        for (int i = 0; i < 300; i++) begin
            drive(1, 200, i % 8, 1, 1);
            step();
        end
        chk("clip_saturate", 64'({oClipCount, oDropCount, oWrEn}), 64'({8'd255, 8'd1, 1'b0}));

        // Queue 8 entries, then reset mid-operation
        for (int i = 0; i < 8; i++) begin
            drive(1, i, 5, 3, 0);
            step();
        end
        chk("eight_queued", 64'({oWrEn, oEmpty, oFull, oAddr}), 64'({1'b1, 1'b0, 1'b0, 15'd800}));
        iResetn = 1'b0;
        drive(1, 1, 1, 1, 1);
        step();
        chk("mid_reset", pack_out(), 64'({1'b0, 15'd0, 3'd0, 1'b0, 1'b1, 8'd0, 8'd0}));
        iResetn = 1'b1;
        drive(0, 0, 0, 0, 0);
        step();
        chk("after_reset_idle", pack_out(), 64'({1'b0, 15'd0, 3'd0, 1'b0, 1'b1, 8'd0, 8'd0}));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
